// File: rtl/cr_cddip_rbus_initiator_if.sv
// Request/response handshake bundle between the test/boot sequencer (master)
// and the rbus ring-head initiator (slave).
interface cr_cddip_rbus_initiator_if #(
  parameter int unsigned ADDR_BITS = 20,
  parameter int unsigned DATA_BITS = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wr_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [1:0]           resp_status;
  logic [DATA_BITS-1:0] resp_rd_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wr_data, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_rd_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wr_data, resp_ready,
    output req_ready, resp_valid, resp_status, resp_rd_data
  );
endinterface

// File: rtl/cr_cddip_rbus_initiator.sv
// Head-of-ring rbus initiator: launches one register request as a one-cycle
// strobe, waits for ack/err_ack or timeout, then holds one response.
module cr_cddip_rbus_initiator #(
  parameter int unsigned ADDR_BITS   = 20,
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  cr_cddip_rbus_initiator_if.slave req_if,
  output logic [ADDR_BITS-1:0] rbus_addr_o,
  output logic                 rbus_wr_strb_o,
  output logic [DATA_BITS-1:0] rbus_wr_data_o,
  output logic                 rbus_rd_strb_o,
  output logic [DATA_BITS-1:0] rbus_rd_data_o,
  output logic                 rbus_ack_o,
  output logic                 rbus_err_ack_o,
  input  logic [DATA_BITS-1:0] rbus_rd_data_i,
  input  logic                 rbus_ack_i,
  input  logic                 rbus_err_ack_i,
  output logic                 busy,
  output logic                 stray_ack
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned STAT_W = 2;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] ST_ACK   = STAT_W'(0);
  localparam logic [STAT_W-1:0] ST_ERR   = STAT_W'(1);
  localparam logic [STAT_W-1:0] ST_TO    = STAT_W'(2);
  localparam logic [STAT_W-1:0] ST_MIS   = STAT_W'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic                 cap_wr_q, cap_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 wr_strb_q, wr_strb_d;
  logic                 rd_strb_q, rd_strb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STAT_W-1:0]    status_q, status_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 stray_q, stray_d;
  logic                 misaligned;
  logic                 any_ack;

  assign misaligned = (req_if.req_addr[1:0] != 2'b00);
  assign any_ack    = rbus_ack_i | rbus_err_ack_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_if.req_valid) state_d = misaligned ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (any_ack || (cnt_q == CNT_LAST)) state_d = RESP;
      RESP:    if (req_if.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ring-head outputs decoded from state and held registers.
  always_comb begin
    req_if.req_ready    = (state_q == IDLE);
    req_if.resp_valid   = (state_q == RESP);
    req_if.resp_status  = status_q;
    req_if.resp_rd_data = rdata_q;
    busy                = (state_q != IDLE);
    stray_ack           = stray_q;
    rbus_addr_o         = addr_q;
    rbus_wr_data_o      = wdata_q;
    rbus_wr_strb_o      = wr_strb_q;
    rbus_rd_strb_o      = rd_strb_q;
    rbus_rd_data_o      = '0;
    rbus_ack_o          = 1'b0;
    rbus_err_ack_o      = 1'b0;
  end

  // Capture, strobe, timeout-counter and response next values.
  always_comb begin
    cap_wr_d  = cap_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_strb_d = 1'b0;
    rd_strb_d = 1'b0;
    cnt_d     = cnt_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    stray_d   = stray_q | (any_ack & (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          cap_wr_d = req_if.req_wr;
          if (misaligned) begin
            status_d = ST_MIS;
            rdata_d  = '0;
          end else begin
            addr_d    = req_if.req_addr;
            wdata_d   = req_if.req_wr_data;
            wr_strb_d = req_if.req_wr;
            rd_strb_d = ~req_if.req_wr;
          end
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // err_ack beats ack, and any ack beats the timeout in the same cycle
        if (rbus_err_ack_i) begin
          status_d = ST_ERR;
          rdata_d  = '0;
        end else if (rbus_ack_i) begin
          status_d = ST_ACK;
          rdata_d  = cap_wr_q ? '0 : rbus_rd_data_i;
        end else if (cnt_q == CNT_LAST) begin
          status_d = ST_TO;
          rdata_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_strb_q <= 1'b0;
      rd_strb_q <= 1'b0;
      cnt_q     <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      stray_q   <= 1'b0;
    end else begin
      cap_wr_q  <= cap_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_strb_q <= wr_strb_d;
      rd_strb_q <= rd_strb_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      stray_q   <= stray_d;
    end
  end

endmodule

// File: tb/tb_cr_cddip_rbus_initiator.sv
// Directed bench for the rbus ring-head initiator: queued expectations for
// strobes and responses, checked by an independent negedge monitor.
module tb_cr_cddip_rbus_initiator;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  localparam int MODE_ACK  = 0;
  localparam int MODE_ERR  = 1;
  localparam int MODE_BOTH = 2;
  localparam int MODE_NONE = 3;

  typedef struct packed {
    logic [1:0]    st;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } strb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] rbus_addr_o;
  logic          rbus_wr_strb_o;
  logic [DW-1:0] rbus_wr_data_o;
  logic          rbus_rd_strb_o;
  logic [DW-1:0] rbus_rd_data_o;
  logic          rbus_ack_o;
  logic          rbus_err_ack_o;
  logic          busy;
  logic          stray_ack;

  logic [DW-1:0] ring_rdata = '0;
  logic          ring_ack   = 1'b0;
  logic          ring_err   = 1'b0;
  logic          man_ack    = 1'b0;
  logic          man_err    = 1'b0;
  int            ring_mode  = MODE_NONE;
  int            ring_lat   = 1;
  logic [DW-1:0] ring_data  = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strb_cyc = 0;
  int resp_cyc = 0;

  resp_t exp_q[$];
  strb_t strb_q[$];

  cr_cddip_rbus_initiator_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  cr_cddip_rbus_initiator #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_if         (bus),
    .rbus_addr_o    (rbus_addr_o),
    .rbus_wr_strb_o (rbus_wr_strb_o),
    .rbus_wr_data_o (rbus_wr_data_o),
    .rbus_rd_strb_o (rbus_rd_strb_o),
    .rbus_rd_data_o (rbus_rd_data_o),
    .rbus_ack_o     (rbus_ack_o),
    .rbus_err_ack_o (rbus_err_ack_o),
    .rbus_rd_data_i (ring_rdata),
    .rbus_ack_i     (ring_ack | man_ack),
    .rbus_err_ack_i (ring_err | man_err),
    .busy           (busy),
    .stray_ack      (stray_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ring responder: registers the strobe, answers ring_lat cycles later for one cycle.
  initial forever begin
    @(negedge clk);
    if (!rst && (rbus_wr_strb_o || rbus_rd_strb_o) && ring_mode != MODE_NONE) begin
      @(posedge clk);
      repeat (ring_lat) @(posedge clk);
      #1;
      ring_ack   = (ring_mode == MODE_ACK) || (ring_mode == MODE_BOTH);
      ring_err   = (ring_mode == MODE_ERR) || (ring_mode == MODE_BOTH);
      ring_rdata = ring_data;
      @(posedge clk);
      #1;
      ring_ack   = 1'b0;
      ring_err   = 1'b0;
      ring_rdata = '0;
    end
  end

  // Monitor: strobe and response scoreboards plus hold-stability of a pending response.
  initial begin : monitor
    logic          prev_strb;
    logic          prev_valid;
    logic          prev_hs;
    logic [1:0]    prev_st;
    logic [DW-1:0] prev_data;
    strb_t         es;
    resp_t         er;
    prev_strb = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
    prev_st = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strb = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
      end else begin
        if (rbus_wr_strb_o || rbus_rd_strb_o) begin
          strb_cyc = cyc;
          if (rbus_wr_strb_o && rbus_rd_strb_o) fail("both_strobes");
          if (prev_strb) fail("strobe_longer_than_1");
          if (strb_q.size() == 0) fail("unexpected_strobe");
          else begin
            es = strb_q.pop_front();
            chk("strobe_is_write", 64'(rbus_wr_strb_o), 64'(es.wr));
            chk("strobe_addr", 64'(rbus_addr_o), 64'(es.addr));
            if (es.wr) chk("strobe_wdata", 64'(rbus_wr_data_o), 64'(es.wdata));
          end
        end
        prev_strb = rbus_wr_strb_o | rbus_rd_strb_o;
        if (bus.resp_valid) begin
          if (!prev_valid || prev_hs) resp_cyc = cyc;
          else begin
            chk("hold_status", 64'(bus.resp_status), 64'(prev_st));
            chk("hold_data", 64'(bus.resp_rd_data), 64'(prev_data));
          end
          if (bus.resp_ready) begin
            if (exp_q.size() == 0) fail("unexpected_response");
            else begin
              er = exp_q.pop_front();
              chk("resp_status", 64'(bus.resp_status), 64'(er.st));
              chk("resp_rd_data", 64'(bus.resp_rd_data), 64'(er.data));
            end
          end
        end
        prev_valid = bus.resp_valid;
        prev_hs    = bus.resp_valid & bus.resp_ready;
        prev_st    = bus.resp_status;
        prev_data  = bus.resp_rd_data;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic exp_resp, input logic [1:0] st, input logic [DW-1:0] rdata);
    int n;
    if (exp_resp) exp_q.push_back('{st: st, data: rdata});
    if (addr[1:0] == 2'b00) strb_q.push_back('{wr: wr, addr: addr, wdata: data});
    bus.req_valid   = 1'b1;
    bus.req_wr      = wr;
    bus.req_addr    = addr;
    bus.req_wr_data = data;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail("req_ready_timeout");
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail("idle_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_status"}, 64'(bus.resp_status), 64'd0);
    chk({tag, "_resp_rd_data"}, 64'(bus.resp_rd_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_stray"}, 64'(stray_ack), 64'd0);
    chk({tag, "_strobes"}, 64'({rbus_wr_strb_o, rbus_rd_strb_o}), 64'd0);
    chk({tag, "_rbus_addr"}, 64'(rbus_addr_o), 64'd0);
    chk({tag, "_rbus_wdata"}, 64'(rbus_wr_data_o), 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wr_data = '0; bus.resp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("init");
    chk("ring_head_ties", 64'({rbus_rd_data_o, rbus_ack_o, rbus_err_ack_o}), 64'd0);

    // Write, ack 3 cycles after the strobe; ring data must not leak into a write response.
    ring_mode = MODE_ACK; ring_lat = 3; ring_data = 32'h5555_AAAA;
    issue(1'b1, 20'h00100, 32'h0001_2344, 1'b1, 2'd0, 32'h0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("write_busy_cycles", 64'(n), 64'd6);
    wait_idle();

    // Read held in RESP for 10 cycles with resp_ready low.
    bus.resp_ready = 1'b0;
    ring_lat = 5; ring_data = 32'hDEAD_BEEF;
    issue(1'b0, 20'h00104, 32'h0, 1'b1, 2'd0, 32'hDEAD_BEEF);
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail("read_resp_timeout");
    repeat (10) begin
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_resp_valid", 64'(bus.resp_valid), 64'd1);
      tick();
    end
    bus.resp_ready = 1'b1;
    chk("pre_hs_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("post_hs_req_ready", 64'(bus.req_ready), 64'd1);
    wait_idle();

    // Timeout, then a late ack becomes stray with no second response.
    chk("stray_before_timeout", 64'(stray_ack), 64'd0);
    ring_mode = MODE_NONE;
    issue(1'b0, 20'h00200, 32'h0, 1'b1, 2'd2, 32'h0);
    wait_idle();
    chk("timeout_latency", 64'(resp_cyc - strb_cyc), 64'd9);
    repeat (3) tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("stray_after_late_ack", 64'(stray_ack), 64'd1);
    repeat (3) begin
      chk("no_second_resp", 64'(bus.resp_valid), 64'd0);
      tick();
    end

    // ack and err_ack together: err wins.
    ring_mode = MODE_BOTH; ring_lat = 2; ring_data = 32'h1234_5678;
    issue(1'b0, 20'h00300, 32'h0, 1'b1, 2'd1, 32'h0);
    wait_idle();

    // ack in the last timeout cycle beats the timeout.
    ring_mode = MODE_ACK; ring_lat = 7; ring_data = 32'h0BAD_F00D;
    issue(1'b0, 20'h00400, 32'h0, 1'b1, 2'd0, 32'h0BAD_F00D);
    wait_idle();
    chk("last_cycle_ack_latency", 64'(resp_cyc - strb_cyc), 64'd9);

    // Misaligned request: no ring activity, ring address untouched.
    issue(1'b1, 20'h00102, 32'h1111_1111, 1'b1, 2'd3, 32'h0);
    wait_idle();
    chk("misaligned_addr_held", 64'(rbus_addr_o), 64'h00400);
    ring_lat = 1;
    issue(1'b1, 20'h00108, 32'hCAFE_F00D, 1'b1, 2'd0, 32'h0);
    wait_idle();

    // Reset mid-WAIT abandons the transaction; a later ack is stray.
    ring_mode = MODE_NONE;
    issue(1'b1, 20'h0010C, 32'h1234_5678, 1'b0, 2'd0, 32'h0);
    repeat (3) tick();
    chk("in_wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midwait_rst");
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("stray_after_reset_ack", 64'(stray_ack), 64'd1);
    repeat (4) begin
      chk("no_resp_after_reset", 64'(bus.resp_valid), 64'd0);
      chk("idle_after_reset", 64'(busy), 64'd0);
      tick();
    end

    chk("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("strobe_queue_empty", 64'(strb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_cddip_rbus_initiator.md
Name: cr_cddip_rbus_initiator

Overview:
- Head-of-ring rbus initiator; the requesting end of the rbus ring protocol that the per-block regfiles answer as responders.
- Accepts one register read/write request on a valid/ready interface and launches it onto the ring as a single-cycle strobe.
- Waits for the returning ack or err_ack, or for a timeout, then presents one response until it is consumed.
- Used by the CDDIP test/boot sequencer to program and read back blocks such as the SA counter regfile.

Parameters:
- ADDR_BITS, 20, rbus address width.
- DATA_BITS, 32, rbus data width.
- TIMEOUT_CYC, 1024, cycles in WAIT before a timeout response; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_BITS  byte address
- req_wr_data  in  DATA_BITS  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_status  out  2  0=ack, 1=err_ack, 2=timeout, 3=misaligned
- resp_rd_data  out  DATA_BITS  read data; 0 unless status=0 and read
- rbus_addr_o  out  ADDR_BITS  ring address
- rbus_wr_strb_o  out  1  ring write strobe
- rbus_wr_data_o  out  DATA_BITS  ring write data
- rbus_rd_strb_o  out  1  ring read strobe
- rbus_rd_data_o  out  DATA_BITS  ring read data out; tied 0 at ring head
- rbus_ack_o  out  1  ring ack out; tied 0 at ring head
- rbus_err_ack_o  out  1  ring err_ack out; tied 0 at ring head
- rbus_rd_data_i  in  DATA_BITS  returning read data
- rbus_ack_i  in  1  returning ack
- rbus_err_ack_i  in  1  returning err_ack
- busy  out  1  state != IDLE
- stray_ack  out  1  sticky: ack or err_ack seen outside WAIT

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State = IDLE.
  - All outputs 0 except req_ready=1.
  - Captured request, response and timeout counter cleared.
  - Reset mid-transaction abandons the transaction. A late ack after reset sets stray_ack.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture wr, addr and data.
  - If addr[1:0] != 0: go to RESP with status=3 and no ring activity.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rbus_addr_o and rbus_wr_data_o driven from the capture registers.
  - rbus_wr_strb_o=wr or rbus_rd_strb_o=!wr, high for this cycle only.
  - Timeout counter loads 0.
  - Go to WAIT.
- rbus_addr_o and rbus_wr_data_o hold their values from ISSUE until the next ISSUE; they are 0 after reset.
- Strobe-to-ack latency is at least 1 cycle. An ack in the ISSUE cycle is treated as stray.
- WAIT (counter increments every cycle):
  - rbus_err_ack_i=1 -> RESP, status=1. This applies even if rbus_ack_i is also 1; err wins.
  - rbus_ack_i=1 -> RESP, status=0. For a read, resp_rd_data captures rbus_rd_data_i in that cycle.
  - Counter reaches TIMEOUT_CYC-1 with no ack -> RESP, status=2.
  - An ack in the same cycle as the timeout wins over the timeout.
  - Write ack: resp_rd_data=0.
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_status and resp_rd_data stay stable until resp_ready.
  - On resp_valid & resp_ready -> IDLE.
  - No back-to-back bypass: at least one IDLE cycle between transactions. Max throughput is 1 transaction per 4 cycles plus ring latency.
- Only one transaction is in flight; req_ready=0 outside IDLE.
- stray_ack:
  - Set by (rbus_ack_i | rbus_err_ack_i) in any state other than WAIT.
  - Cleared only by rst.
  - A stray ack does not change state or the response.
- An ack arriving after a timeout, while in RESP or IDLE, counts as stray and is not delivered.
- Timeout counter is 16 bits and saturates; it does not wrap.

Test Plan:
- Write 0x0001_2344 to addr 0x00100; ring model acks 3 cycles after the strobe. Required:
  - rbus_wr_strb_o high for exactly 1 cycle with addr 0x00100.
  - resp_status=0, resp_rd_data=0.
  - busy high for 6 cycles with resp_ready tied 1.
- Read addr 0x00104; ring returns ack with rd_data 0xDEADBEEF after 5 cycles; resp_ready held low for 10 cycles. Required:
  - resp_valid, status=0 and data 0xDEADBEEF stay stable the whole time.
  - req_ready=0 until 1 cycle after the resp handshake.
- Read with no ack, TIMEOUT_CYC=8. Required:
  - resp_status=2 exactly 8 cycles after entering WAIT.
  - An ack injected 4 cycles later sets stray_ack=1 and produces no second response.
- Ack and err_ack in the same cycle. Required: status=1. Also ack in the final timeout cycle, required: status=0.
- Request addr 0x00102. Required:
  - status=3 with no strobes ever asserted.
  - The next aligned request proceeds normally.
- rst asserted in WAIT, then an ack 2 cycles later. Required:
  - All outputs reset on the edge and req_ready=1.
  - stray_ack=1 after the ack; no response is issued.
